// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: local history width and its vector type,
// used by the local history table, the local prediction table and the chooser.
package bp_pkg;

    localparam int LHT_HIST_W = 10;

    typedef logic [LHT_HIST_W-1:0] lhist_t;

endpackage : bp_pkg

// File: rtl/local_history_table.sv
// Single-branch local history shift register for a tournament predictor.
// Newest resolved outcome lands in bit 0; the oldest bit falls off the MSB.
module local_history_table
    import bp_pkg::*;
#(
    parameter int HIST_W = LHT_HIST_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              BranchTaken,
    output logic [HIST_W-1:0] LHresult
);

    logic [HIST_W-1:0] hist_q;
    logic [HIST_W-1:0] hist_d;

    always_comb begin
        hist_d = {hist_q[HIST_W-2:0], BranchTaken};
    end

    // Reset wins over the shift, so an unknown BranchTaken during reset never reaches hist_q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign LHresult = hist_q;

    a_reset_clears : assert property (
        @(posedge clock) !reset |-> (hist_q == '0)
    ) else $error("local_history_table: history not cleared while reset is low");

    // Two consecutive edges out of reset: this edge's value is last edge's shift.
    a_shift : assert property (
        @(posedge clock) disable iff (!reset)
        $past(reset) |-> (hist_q == {$past(hist_q[HIST_W-2:0]), $past(BranchTaken)})
    ) else $error("local_history_table: history did not shift correctly");

    a_no_x : assert property (
        @(posedge clock) disable iff (!reset)
        !$isunknown($past(BranchTaken)) |-> !$isunknown(hist_q)
    ) else $error("local_history_table: unknown bits in history");

endmodule : local_history_table

// File: tb/tb_local_history_table.sv
// Directed bench for local_history_table: expected histories are queued as each
// outcome is driven and popped at the following falling edge.
module tb_local_history_table;
    import bp_pkg::*;

    localparam int HIST_W = LHT_HIST_W;

    logic              clock;
    logic              reset;
    logic              BranchTaken;
    logic [HIST_W-1:0] LHresult;

    logic [HIST_W-1:0] exp_q[$];
    logic [HIST_W-1:0] model;
    int                pass_cnt;
    int                total_cnt;

    local_history_table #(.HIST_W(HIST_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .BranchTaken (BranchTaken),
        .LHresult    (LHresult)
    );

    // Clock and reset: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic compare(input string tag, input logic [HIST_W-1:0] got,
                           input logic [HIST_W-1:0] want);
        total_cnt++;
        assert (got === want) pass_cnt++;
        else $error("FAIL %s: LHresult=%b expected=%b", tag, got, want);
    endtask

    task automatic check_pop(input string tag);
        logic [HIST_W-1:0] want;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $error("FAIL %s: scoreboard empty, LHresult=%b expected=<queued value>", tag, LHresult);
        end else begin
            want = exp_q.pop_front();
            compare(tag, LHresult, want);
        end
    endtask

    // Driver: present an outcome after the falling edge, let one rising edge
    // shift it in, then compare at the next falling edge.
    task automatic step(input logic bt, input string tag);
        BranchTaken = bt;
        model = {model[HIST_W-2:0], bt};
        exp_q.push_back(model);
        @(posedge clock);
        @(negedge clock);
        check_pop(tag);
    endtask

    task automatic reset_cycle(input string tag);
        BranchTaken = 1'bx;
        model = '0;
        exp_q.push_back(model);
        @(posedge clock);
        @(negedge clock);
        check_pop(tag);
    endtask

    initial begin
        logic [HIST_W-1:0] held;
        pass_cnt    = 0;
        total_cnt   = 0;
        model       = '0;
        reset       = 1'b0;
        BranchTaken = 1'bx;

        for (int i = 0; i < 3; i++) reset_cycle("reset_hold");

        reset = 1'b1;
        step(1'b0, "release_0");
        step(1'b1, "release_1");
        step(1'b1, "release_11");
        compare("after_011", LHresult, 10'b0000000011);

        for (int i = 0; i < 8; i++) step(1'b0, "shift_zeros");
        compare("after_8_zeros", LHresult, 10'b1100000000);

        for (int i = 0; i < 4; i++) step(1'b1, "shift_ones");
        compare("after_4_ones", LHresult, 10'b0000001111);

        // BranchTaken changes between edges must not reach the output.
        held = LHresult;
        BranchTaken = 1'b0;
        #1;
        compare("no_comb_path", LHresult, held);

        // Mid-cycle asynchronous reset, well before the next rising edge.
        #1;
        reset = 1'b0;
        BranchTaken = 1'bx;
        #1;
        compare("async_clear", LHresult, '0);
        @(negedge clock);
        compare("async_hold", LHresult, '0);
        for (int i = 0; i < 2; i++) reset_cycle("reset_repeat");

        reset = 1'b1;
        model = '0;
        for (int i = 0; i < 10; i++) step(1'b1, "fill_ones");
        compare("full_ones", LHresult, 10'b1111111111);
        step(1'b0, "msb_discard");
        compare("msb_discard_const", LHresult, 10'b1111111110);

        for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), "random");

        if (exp_q.size() != 0) begin
            total_cnt++;
            $error("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_local_history_table

// File: doc/local_history_table.md
Name: local_history_table

Overview:
- Per-branch local history register for the Alpha 21264-style tournament branch predictor.
- Holds the last HIST_W resolved outcomes of one branch as a shift register; the newest outcome is in the LSB.
- Output feeds the local prediction table as its index, and the tournament logic as context.
- Single-entry building block; a PC-indexed array of these is built at a higher level.

Parameters:
- HIST_W, 10, history length in bits (width of LHresult).

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears history immediately.
- BranchTaken  input  1  resolved outcome shifted in this cycle; 1 = taken, 0 = not taken.
- LHresult  output  HIST_W  current local history; bit 0 = most recent outcome.

Behaviour:
- Reset (reset=0): LHresult forced to all zeros asynchronously, without waiting for a clock edge. Held at zero for as long as reset is low.
- BranchTaken is ignored while reset is low, including X/Z values. No X may propagate into the history.
- Normal operation (reset=1): on every rising clock edge, LHresult <= {LHresult[HIST_W-2:0], BranchTaken}.
- There is no enable. Every clock edge out of reset is one update.
- The oldest bit (MSB) is discarded on each shift. There is no saturation or wrap-around logic.
- Latency: the new value is visible immediately after the rising edge. It is stable at the following falling edge, where benches sample.
- Reset release: the first update occurs on the first rising edge with reset=1 and shifts into the all-zero history.
- Reset mid-operation: history clears at once, independent of the clock. Updates resume from zero after release.
- Repeated resets are idempotent; output stays zero.
- Output is a direct register output, with no combinational path from BranchTaken.
- Implementation: a single always_ff sensitive to posedge clock and negedge reset. Reset has priority.
- Include SVA properties:
  - After reset falls, LHresult == 0.
  - $past-based shift check when reset has been high for 2+ cycles.
  - LHresult never contains X when reset=1 and the previous input was known.

Decomposition:
- Shared package bp_pkg: localparam LHT_HIST_W = 10 and typedef logic [LHT_HIST_W-1:0] lhist_t. Reused by the local prediction table and the tournament chooser.
- No sub-module; the block is a single register with its assertion section.

Test Plan:
- Reset held for 3 cycles with BranchTaken=X -> LHresult = 0000000000 at each falling edge.
- Release reset, drive 0,1,1 -> LHresult 0000000000, 0000000001, 0000000011.
- Continue 8× BranchTaken=0 -> final LHresult = 1100000000; intermediate values shift left by one each cycle.
- Continue 4× BranchTaken=1 -> final LHresult = 0000001111 (old ones shifted out of the MSB).
- Assert reset low mid-cycle, between clock edges, while history = 0000001111 -> LHresult = 0000000000 before the next rising edge; stays 0 until release.
- After release, 10× BranchTaken=1 -> 1111111111; then one 0 -> 1111111110 (MSB discard at full width).
